ps2_key_rx: RTL and testbench
=============================

PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 18432, the clk_sys cycles without a falling PS/2 clock edge after which a partial frame is discarded.
REQ-002 SHALL have parameter FILTER_LEN, default 8, the consecutive equal clk_sys samples needed before a PS/2 line change is accepted.
REQ-003 SHALL have port clk_sys  in  1  system clock; the only clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk_in  in  1  raw PS/2 clock line, asynchronous.
REQ-006 SHALL have port ps2_data_in  in  1  raw PS/2 data line, asynchronous.
REQ-007 SHALL have port ps2_key  out  65  bit 64 is the event toggle; bits 63:0 hold the byte sequence, newest byte in 7:0.
REQ-008 SHALL have port frame_err  out  1  one-cycle pulse when a frame is dropped.

Function
REQ-009 SHALL pass each PS/2 line through a 2-flop synchronizer, then a FILTER_LEN-sample glitch filter; only filtered levels are used downstream.
REQ-010 SHALL sample data on each filtered ps2_clk falling edge.
REQ-011 Frame format SHALL be start(0), 8 data bits LSB first, odd parity, stop(1); a bit counter 0..10 tracks position.
REQ-012 States SHALL be IDLE, SHIFT, CHECK. IDLE->SHIFT on an edge with data=0. An edge with data=1 in IDLE SHALL be ignored without an error.
REQ-013 SHIFT SHALL collect 8 data bits and the parity bit, and SHALL move to CHECK on the stop-bit edge.
REQ-014 CHECK SHALL last one cycle, then return to IDLE. stop=0 SHALL drop the byte and pulse frame_err.
REQ-015 Timeout: in SHIFT, a count reaching TIMEOUT_CYCLES since the last edge SHALL return to IDLE, drop the partial byte and pulse frame_err. The count SHALL be cleared on every edge and in IDLE.
REQ-016 Accepted bytes SHALL shift into a 64-bit sequence register: seq <= {seq[55:0], byte}. Bytes older than 8 are lost, with no error.
REQ-017 Bytes E0 and F0 SHALL be prefixes: store only, no event.
REQ-018 Byte E1 SHALL be stored and SHALL start a pause sequence; the 7th byte after it SHALL be terminal, whatever its value.
REQ-019 Any other byte outside a pause sequence SHALL be terminal.
REQ-020 On a terminal byte the block SHALL:
  - set ps2_key[63:0] <= {seq[55:0], byte};
  - invert ps2_key[64];
  - clear seq and the pause count.
  All three SHALL occur in the cycle after CHECK, giving a latency of 1 clk_sys from the end of CHECK.
REQ-021 ps2_key[63:0] SHALL hold its value between events. Exactly one toggle SHALL occur per terminal byte.
REQ-022 A dropped frame (parity, stop or timeout) SHALL leave seq, the pause count and ps2_key unchanged.
REQ-023 A timeout and an edge in the same cycle SHALL be resolved in favour of the edge.

Reset
REQ-024 reset SHALL:
  - set ps2_key to 0 and frame_err to 0;
  - clear seq, the pause count, the bit counter and the timeout count;
  - put the state to IDLE;
  - preset the synchronizer and filter outputs to 1, the idle line level.
REQ-025 reset asserted mid-frame or mid-sequence SHALL abort it. No event and no frame_err SHALL be produced for the aborted frame.

Configuration
REQ-026 Macro PS2_PARITY_CHECK_EN defined: in CHECK, a parity mismatch SHALL drop the byte and pulse frame_err.
REQ-027 Macro PS2_PARITY_CHECK_EN undefined: the parity bit SHALL still be clocked through but ignored. Only stop-bit errors and timeouts SHALL pulse frame_err.

Verification
REQ-028 Frame for byte 29 (space key), correct parity -> ps2_key[7:0]=29, ps2_key[63:8]=0, bit 64 toggles once.
REQ-029 Bytes E0, F0, 75 -> one toggle only; ps2_key[23:0]=E0F075.
REQ-030 Bytes E1 14 77 E1 F0 14 F0 77 -> one toggle only; ps2_key[63:0]=E11477E1F014F077.
REQ-031 Byte 05 with a wrong parity bit:
  - with PS2_PARITY_CHECK_EN: frame_err pulses once and ps2_key does not change;
  - without it: ps2_key[7:0]=05 and bit 64 toggles.
REQ-032 Start bit plus 4 data bits, then the PS/2 clock idle for TIMEOUT_CYCLES+1 -> frame_err pulses once. A following valid 6B frame -> ps2_key[7:0]=6B.
REQ-033 1-cycle glitches on ps2_clk_in during a frame -> no extra bits captured, byte 72 decoded correctly. reset asserted after 5 bits of a frame -> ps2_key=0 and no event.

Source files
------------

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame decode and
// scan-code sequence assembly into a 64-bit key word with an event toggle.
// Ports: clk_sys, reset (sync, active high), ps2_clk_in, ps2_data_in (raw,
// async); ps2_key[64] event toggle, [63:0] byte sequence (newest in 7:0);
// frame_err one-cycle pulse on a dropped frame.
// Option: define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module ps2_key_rx #(
  parameter int TIMEOUT_CYCLES = 18432,
  parameter int FILTER_LEN     = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [64:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  // index 0 = PS/2 clock, index 1 = PS/2 data
  logic [1:0]    raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    flt;
  logic [FW-1:0] fcnt [2];

  assign raw = {ps2_data_in, ps2_clk_in};

  // A change is taken only after FILTER_LEN equal samples of the new level.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1  <= '1;
      s2  <= '1;
      flt <= '1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == flt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          flt[i]  <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  logic clk_prev;
  logic fall;

  assign fall = clk_prev & ~flt[0];

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic          stop_bit;
  logic [TW-1:0] to_cnt;
  logic          start;
  logic          shift_en;
  logic          stop_en;
  logic          tmo;
  logic          accept;
  logic          drop;
  logic          frame_ok;

  // shreg[8] is parity, shreg[7:0] the data byte
  assign frame_ok = stop_bit & ((^shreg) | ~PAR_EN);

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    stop_en   = 1'b0;
    tmo       = 1'b0;
    accept    = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall && !flt[1]) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // an edge wins over an expiring timeout
        if (fall) begin
          if (bit_cnt == 4'd10) begin
            stop_en   = 1'b1;
            state_nxt = CHECK;
          end else begin
            shift_en = 1'b1;
          end
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        if (frame_ok) accept = 1'b1;
        else          drop   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_prev  <= 1'b1;
      bit_cnt   <= '0;
      shreg     <= '0;
      stop_bit  <= 1'b0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      clk_prev  <= flt[0];
      frame_err <= drop | tmo;
      if (start) begin
        bit_cnt <= 4'd1;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {flt[1], shreg[8:1]};
      end
      if (stop_en) stop_bit <= flt[1];
      if (state != SHIFT || fall || tmo) to_cnt <= '0;
      else                               to_cnt <= to_cnt + 1'b1;
    end
  end

  logic [7:0]  rx_byte;
  logic [63:0] seq;
  logic [2:0]  pause_cnt;
  logic [2:0]  pause_nxt;
  logic        in_pause;
  logic        is_pfx;
  logic        term;

  assign rx_byte  = shreg[7:0];
  assign in_pause = pause_cnt != 3'd0;
  assign is_pfx   = rx_byte == 8'hE0 || rx_byte == 8'hF0;

  // pause_cnt counts bytes after E1; the 7th one closes the sequence
  always_comb begin
    term      = 1'b0;
    pause_nxt = pause_cnt;
    unique case (1'b1)
      in_pause: begin
        term      = pause_cnt == 3'd7;
        pause_nxt = pause_cnt + 3'd1;
      end
      !in_pause && is_pfx: ;
      !in_pause && rx_byte == 8'hE1: pause_nxt = 3'd1;
      default: term = 1'b1;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ps2_key   <= '0;
      seq       <= '0;
      pause_cnt <= '0;
    end else if (accept) begin
      if (term) begin
        ps2_key   <= {~ps2_key[64], seq[55:0], rx_byte};
        seq       <= '0;
        pause_cnt <= '0;
      end else begin
        seq       <= {seq[55:0], rx_byte};
        pause_cnt <= pause_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: directed and random PS/2 frames, scoreboard queue
// filled by a byte-level reference model, checked by a negedge monitor.
`timescale 1ns/1ps
module tb_ps2_key_rx;

  localparam int TO = 1000;
  localparam int FL = 8;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [64:0] ps2_key;
  logic        frame_err;

  always #5 clk_sys = ~clk_sys;

  ps2_key_rx #(
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FL)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_key(ps2_key),
    .frame_err(frame_err)
  );

  typedef struct packed {
    logic        is_err;
    logic [64:0] key;
  } exp_t;

  exp_t        expq[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  seq_q[$];
  int          pause_left = 0;
  logic        exp_tog = 1'b0;
  logic [64:0] last_key = '0;

  task automatic check(input string name, input logic [64:0] act,
                       input logic [64:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_chk++;
    $display("FAIL %s: got output expected none", name);
  endtask

  function automatic exp_t mk(input logic e, input logic [64:0] k);
    exp_t r;
    r.is_err = e;
    r.key    = k;
    return r;
  endfunction

  // Reference: keep all bytes since the last event; an event reports the
  // newest eight of them.
  task automatic model_byte(input logic [7:0] b);
    logic        t;
    logic [63:0] v;
    int          first;
    t = 1'b0;
    seq_q.push_back(b);
    if (pause_left > 0) begin
      pause_left--;
      t = pause_left == 0;
    end else if (b == 8'hE0 || b == 8'hF0) begin
      t = 1'b0;
    end else if (b == 8'hE1) begin
      pause_left = 7;
    end else begin
      t = 1'b1;
    end
    if (t) begin
      v = '0;
      first = seq_q.size() > 8 ? seq_q.size() - 8 : 0;
      for (int i = first; i < seq_q.size(); i++) v = {v[55:0], seq_q[i]};
      exp_tog  = ~exp_tog;
      last_key = {exp_tog, v};
      expq.push_back(mk(1'b0, last_key));
      seq_q.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic g);
    repeat (5) tick();
    if (g) begin
      ps2_clk_in = 1'b0;
      tick();
      ps2_clk_in = 1'b1;
    end
    repeat (4) tick();
    ps2_data_in = b;
    repeat (10) tick();
    ps2_clk_in = 1'b0;
    repeat (10) tick();
    if (g) begin
      ps2_clk_in = 1'b1;
      tick();
      ps2_clk_in = 1'b0;
    end
    repeat (9) tick();
    ps2_clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic bad_stop, input logic g);
    logic par;
    par = (~^b) ^ bad_par;
    if (bad_stop || (PAR_EN && bad_par)) expq.push_back(mk(1'b1, '0));
    else model_byte(b);
    send_bit(1'b0, g);
    for (int i = 0; i < 8; i++) send_bit(b[i], g);
    send_bit(par, g);
    send_bit(~bad_stop, g);
    ps2_data_in = 1'b1;
    repeat (60) tick();
  endtask

  logic       prev_tog;
  logic [63:0] prev_key;

  always @(negedge clk_sys) begin
    exp_t e;
    if (reset) begin
      prev_tog = ps2_key[64];
      prev_key = ps2_key[63:0];
    end else begin
      if (ps2_key[64] !== prev_tog) begin
        if (expq.size() == 0) begin
          flag("unexpected_key_event");
        end else begin
          e = expq.pop_front();
          check("event_kind", {64'd0, ps2_key[64] !== prev_tog && e.is_err},
                65'd0);
          check("key_value", ps2_key, e.key);
        end
      end else if (ps2_key[63:0] !== prev_key) begin
        flag("key_changed_without_toggle");
      end
      if (frame_err === 1'b1) begin
        if (expq.size() == 0) begin
          flag("unexpected_frame_err");
        end else begin
          e = expq.pop_front();
          check("err_kind", {64'd0, e.is_err}, 65'd1);
        end
      end
      prev_tog = ps2_key[64];
      prev_key = ps2_key[63:0];
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int         r;
    reset = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    check("reset_key", ps2_key, 65'd0);
    check("reset_err", {64'd0, frame_err}, 65'd0);

    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h14, 1'b0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h14, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    send_frame(8'h05, 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);

    // partial frame then silence: start + 4 data bits
    expq.push_back(mk(1'b1, '0));
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    ps2_data_in = 1'b1;
    repeat (TO + 50) tick();
    send_frame(8'h6B, 1'b0, 1'b0, 1'b0);

    send_frame(8'h72, 1'b0, 1'b0, 1'b1);

    // reset during a prefix sequence and mid-frame
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    ps2_data_in = 1'b1;
    reset = 1'b1;
    seq_q.delete();
    pause_left = 0;
    exp_tog = 1'b0;
    last_key = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("mid_frame_reset_key", ps2_key, 65'd0);
    repeat (60) tick();
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15)      rb = 8'hE0;
      else if (r < 30) rb = 8'hF0;
      else if (r < 38) rb = 8'hE1;
      else             rb = 8'($urandom);
      send_frame(rb, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < 2000 && expq.size() > 0; i++) tick();
    if (expq.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    check("final_key", ps2_key, last_key);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
